// File: rtl/serial_parity_framer_pkg.sv
// parity_pkg: FSM state type and parity/mode constants shared by the framer and its bench
package parity_pkg;
  typedef enum logic [0:0] {S_DATA, S_PARITY} pf_state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;
endpackage

// File: rtl/serial_parity_framer_if.sv
// serial_parity_framer_if: mode select, in_valid/in_ready/in_bit input handshake and registered out_* stream
interface serial_parity_framer_if;
  logic odd;
  logic check;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_is_parity;
  logic frame_done;
  logic parity_err;
  modport master (
    output odd, check, in_valid, in_bit,
    input  in_ready, out_valid, out_bit, out_is_parity, frame_done, parity_err
  );
  modport slave (
    input  odd, check, in_valid, in_bit,
    output in_ready, out_valid, out_bit, out_is_parity, frame_done, parity_err
  );
endinterface

// File: rtl/serial_parity_framer_acc.sv
// parity_acc: XOR accumulator (clk, reset, clear loads d, en xors d, acc running parity)
module parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic acc
);
  logic acc_q, acc_d;
  always_comb acc_d = clear ? d : en ? acc_q ^ d : acc_q;
  always_ff @(posedge clk) acc_q <= reset ? 1'b0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/serial_parity_framer.sv
// serial_parity_framer: serial parity generate/check framer (clk, sync reset, bus: odd/check mode, in handshake, registered out stream)
module serial_parity_framer #(
  parameter int DATA_BITS = 8
) (
  input logic clk,
  input logic reset,
  serial_parity_framer_if.slave bus
);
  import parity_pkg::*;
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] PIDX = CW'(DATA_BITS);
  pf_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic odd_q, odd_d, check_q, check_d;
  logic out_valid_q, out_valid_d, out_bit_q, out_bit_d;
  logic out_is_parity_q, out_is_parity_d, frame_done_q, frame_done_d, parity_err_q, parity_err_d;
  logic acc, accept, first, chk, par_slot, gen_par, gen_last, exp_par;
  assign bus.in_ready = !reset && state_q == S_DATA;
  assign accept = bus.in_valid && bus.in_ready;
  assign first = cnt_q == '0;
  parity_acc u_acc (
    .clk(clk),
    .reset(reset),
    .clear(accept && first),
    .en(accept && !first && !par_slot),
    .d(bus.in_bit),
    .acc(acc)
  );
  always_comb begin
    odd_d = accept && first ? bus.odd : odd_q;
    check_d = accept && first ? bus.check : check_q;
    chk = check_d == MODE_CHK;
    par_slot = accept && chk && cnt_q == PIDX;
    gen_last = accept && !chk && cnt_q == LAST;
    gen_par = state_q == S_PARITY;
    exp_par = acc ^ (odd_q == PAR_ODD);
    state_d = gen_par ? S_DATA : gen_last ? S_PARITY : state_q;
    cnt_d = !accept ? cnt_q : (par_slot || gen_last) ? '0 : cnt_q + 1'b1;
    out_valid_d = accept || gen_par;
    out_bit_d = accept ? bus.in_bit : gen_par ? exp_par : 1'b0;
    out_is_parity_d = gen_par || par_slot;
    frame_done_d = gen_par || par_slot;
    parity_err_d = par_slot && (bus.in_bit ^ exp_par);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DATA;
      cnt_q <= '0;
      odd_q <= PAR_EVEN;
      check_q <= MODE_GEN;
      out_valid_q <= 1'b0;
      out_bit_q <= 1'b0;
      out_is_parity_q <= 1'b0;
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      odd_q <= odd_d;
      check_q <= check_d;
      out_valid_q <= out_valid_d;
      out_bit_q <= out_bit_d;
      out_is_parity_q <= out_is_parity_d;
      frame_done_q <= frame_done_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit = out_bit_q;
  assign bus.out_is_parity = out_is_parity_q;
  assign bus.frame_done = frame_done_q;
  assign bus.parity_err = parity_err_q;
endmodule

// File: tb/tb_serial_parity_framer.sv
// tb_serial_parity_framer: directed stimulus with queued expectations checked by an output monitor
module tb_serial_parity_framer;
  import parity_pkg::*;
  typedef struct packed {
    logic b;
    logic p;
    logic d;
    logic e;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  serial_parity_framer_if bus ();
  serial_parity_framer #(.DATA_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) cmp("spurious out_valid", {4'b0, bus.out_valid}, 5'd0);
      else begin
        mon_e = q.pop_front();
        cmp("out {bit,is_par,done,err}", {1'b0, bus.out_bit, bus.out_is_parity, bus.frame_done, bus.parity_err}, {1'b0, mon_e});
      end
    end
  end
  task automatic send(input logic b, input logic o, input logic c, input logic p, input logic d, input logic e);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_bit = b;
    bus.odd = o;
    bus.check = c;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      cmp("accept timeout", 5'(w), 5'd0);
      bus.in_valid = 1'b0;
    end else begin
      q.push_back({b, p, d, e});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic gen_tail(input logic par);
    cmp("gen in_ready low", {4'b0, bus.in_ready}, 5'd0);
    q.push_back({par, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
  endtask
  task automatic gen_frame(input logic [7:0] bits, input logic o, input logic par);
    for (int i = 0; i < 8; i++) send(bits[7-i], o, MODE_GEN, 1'b0, 1'b0, 1'b0);
    gen_tail(par);
    cmp("gen in_ready back", {4'b0, bus.in_ready}, 5'd1);
  endtask
  task automatic check_frame(input logic [7:0] bits, input logic o, input logic pbit, input logic err);
    for (int i = 0; i < 8; i++) begin
      send(bits[7-i], o, MODE_CHK, 1'b0, 1'b0, 1'b0);
      cmp("chk in_ready", {4'b0, bus.in_ready}, 5'd1);
    end
    send(pbit, o, MODE_CHK, 1'b1, 1'b1, err);
    cmp("chk in_ready end", {4'b0, bus.in_ready}, 5'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    logic [7:0] gap_bits;
    logic [7:0] hold_bits;
    gap_bits = 8'b10101010;
    hold_bits = 8'b10110000;
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b1;
    bus.odd = 1'b0;
    bus.check = 1'b0;
    repeat (2) begin
      @(negedge clk);
      cmp("reset in_ready", {4'b0, bus.in_ready}, 5'd0);
      cmp("reset outs", {bus.out_valid, bus.out_bit, bus.out_is_parity, bus.frame_done, bus.parity_err}, 5'd0);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    cmp("post-reset in_ready", {4'b0, bus.in_ready}, 5'd1);
    cmp("post-reset out_valid", {4'b0, bus.out_valid}, 5'd0);
    gen_frame(8'b10110000, PAR_EVEN, 1'b1);
    gen_frame(8'b10110000, PAR_ODD, 1'b0);
    gen_frame(8'b00000000, PAR_EVEN, 1'b0);
    gen_frame(8'b00000000, PAR_ODD, 1'b1);
    check_frame(8'b11000000, PAR_EVEN, 1'b1, 1'b1);
    check_frame(8'b11000000, PAR_EVEN, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(gap_bits[7-i], PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
      if (i < 7) begin
        @(negedge clk);
        cmp("gap idle out_valid", {4'b0, bus.out_valid}, 5'd0);
      end
    end
    gen_tail(1'b0);
    for (int i = 0; i < 8; i++) send(hold_bits[7-i], PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b1;
    bus.odd = PAR_EVEN;
    gen_tail(1'b1);
    bus.odd = PAR_ODD;
    send(1'b1, PAR_ODD, MODE_GEN, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(1'b0, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
    gen_tail(1'b0);
    for (int i = 0; i < 8; i++) send(hold_bits[7-i], (i < 3) ? PAR_EVEN : PAR_ODD, MODE_GEN, 1'b0, 1'b0, 1'b0);
    gen_tail(1'b1);
    send(1'b1, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
    send(1'b0, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
    send(1'b1, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
    send(1'b1, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp("mid-frame reset in_ready", {4'b0, bus.in_ready}, 5'd0);
    reset = 1'b0;
    @(negedge clk);
    gen_frame(8'hFF, PAR_EVEN, 1'b0);
    repeat (3) @(negedge clk);
    cmp("queue drained", 5'(q.size()), 5'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
